vram_scan_dp: RTL

Dual-port video RAM for the Nios subsystem: an Avalon-MM slave port lets the CPU write and read the frame buffer, and an independent scan-out engine streams a programmable window of words to the display pipeline over a valid/ready interface. Width and depth are parametrised. The block adds registered reads with `readdatavalid`, back-pressured streaming, address wrap-around and a loop mode. It sits between the Nios data master and the pixel serializer.

---
 rtl/vram_pkg.sv | 16 +
 rtl/vram_dp_mem.sv | 46 ++++
 rtl/vram_scan_dp.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/vram_pkg.sv
// Shared types and helpers for the dual-port video RAM and its scan-out engine.
package vram_pkg;

  typedef enum logic [1:0] {
    SCAN_IDLE,
    SCAN_RUN,
    SCAN_DRAIN
  } scan_state_t;

  localparam int unsigned FIFO_DEPTH = 3;

  function automatic int unsigned byte_lanes(input int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/vram_dp_mem.sv
// True dual-port RAM: byte-writable read/write port A, read-only port B,
// registered reads on both ports, old data returned on a same-word collision.
module vram_dp_mem
  import vram_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 10,
  parameter              INIT_FILE = "vram_scan_dp.hex"
) (
  input  logic                          clk,
  input  logic                          a_rd,
  input  logic                          a_wr,
  input  logic [ADDR_W-1:0]             a_addr,
  input  logic [byte_lanes(DATA_W)-1:0] a_be,
  input  logic [DATA_W-1:0]             a_wdata,
  output logic [DATA_W-1:0]             a_q,
  input  logic                          b_rd,
  input  logic [ADDR_W-1:0]             b_addr,
  output logic [DATA_W-1:0]             b_q
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned LANES = byte_lanes(DATA_W);

  logic [DATA_W-1:0] mem [DEPTH];

  // The preload image is bound to the array by the FPGA RAM flow; the RTL
  // never clears the contents.
  if (INIT_FILE != "") begin : g_init_image
  end

  always_ff @(posedge clk) begin
    if (a_rd)
      a_q <= mem[a_addr];
    if (a_wr)
      for (int unsigned i = 0; i < LANES; i++)
        if (a_be[i])
          mem[a_addr][i*8 +: 8] <= a_wdata[i*8 +: 8];
  end

  always_ff @(posedge clk) begin
    if (b_rd)
      b_q <= mem[b_addr];
  end

endmodule

// File: rtl/vram_scan_dp.sv
// Video RAM: Avalon-MM CPU port plus a scan-out engine streaming a programmable
// window of words over valid/ready through a 3-entry output FIFO.
module vram_scan_dp
  import vram_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 10,
  parameter              INIT_FILE = "vram_scan_dp.hex"
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clken,
  input  logic [ADDR_W-1:0]             address,
  input  logic [byte_lanes(DATA_W)-1:0] byteenable,
  input  logic                          chipselect,
  input  logic                          read,
  input  logic                          write,
  input  logic [DATA_W-1:0]             writedata,
  output logic [DATA_W-1:0]             readdata,
  output logic                          readdatavalid,
  input  logic [ADDR_W-1:0]             scan_base,
  input  logic [ADDR_W:0]               scan_len,
  input  logic                          scan_start,
  input  logic                          scan_loop,
  input  logic                          scan_abort,
  output logic                          scan_busy,
  output logic                          frame_done,
  output logic [DATA_W-1:0]             pix_data,
  output logic                          pix_valid,
  input  logic                          pix_ready,
  output logic                          pix_sof,
  output logic                          pix_eof
);

  localparam logic [ADDR_W:0] REM_ONE = {{ADDR_W{1'b0}}, 1'b1};

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'(FIFO_DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  logic              a_rd, a_wr;
  logic [DATA_W-1:0] a_q, b_q;

  scan_state_t       state, state_next;
  logic              launch, loop_r, first_r;
  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W:0]   remain_r;
  logic              issue, last, relatch, credit;
  logic              rd_vld, rd_sof, rd_eof;

  logic [DATA_W-1:0]     fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_sof, fifo_eof;
  logic [1:0]            wr_ptr, rd_ptr, fifo_count;
  logic                  pop;

  vram_dp_mem #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .INIT_FILE(INIT_FILE)
  ) u_mem (
    .clk    (clk),
    .a_rd   (a_rd),
    .a_wr   (a_wr),
    .a_addr (address),
    .a_be   (byteenable),
    .a_wdata(writedata),
    .a_q    (a_q),
    .b_rd   (issue),
    .b_addr (addr_r),
    .b_q    (b_q)
  );

  // CPU port
  assign a_rd = chipselect & read & clken;
  assign a_wr = chipselect & write & clken;

  always_ff @(posedge clk) begin
    if (reset) readdatavalid <= 1'b0;
    else       readdatavalid <= a_rd;
  end

  assign readdata = readdatavalid ? a_q : '0;

  // Scan FSM
  always_ff @(posedge clk) begin
    if (reset) state <= SCAN_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    credit     = ({1'b0, fifo_count} + {2'b00, rd_vld}) < 3'(FIFO_DEPTH);
    last       = (remain_r == REM_ONE);
    unique case (state)
      SCAN_IDLE:
        if (scan_start && scan_len != '0) state_next = SCAN_RUN;
      SCAN_RUN:
        if (!launch && credit) begin
          issue = 1'b1;
          if (last && !(loop_r && scan_loop && scan_len != '0))
            state_next = SCAN_DRAIN;
        end
      SCAN_DRAIN:
        // Only the final word remains once nothing is in flight and one entry is left.
        if (pop && fifo_count == 2'd1 && !rd_vld) state_next = SCAN_IDLE;
      default:
        state_next = SCAN_IDLE;
    endcase
    if (scan_abort) begin
      state_next = SCAN_IDLE;
      issue      = 1'b0;
    end
    relatch = issue & last & loop_r & scan_loop & (scan_len != '0);
  end

  // Address counter; the launch slot delays the first issue by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      launch   <= 1'b0;
      loop_r   <= 1'b0;
      first_r  <= 1'b0;
      addr_r   <= '0;
      remain_r <= '0;
      rd_vld   <= 1'b0;
      rd_sof   <= 1'b0;
      rd_eof   <= 1'b0;
    end else begin
      launch <= 1'b0;
      if (state == SCAN_IDLE && state_next == SCAN_RUN) begin
        launch   <= 1'b1;
        addr_r   <= scan_base;
        remain_r <= scan_len;
        loop_r   <= scan_loop;
        first_r  <= 1'b1;
      end else if (relatch) begin
        addr_r   <= scan_base;
        remain_r <= scan_len;
        first_r  <= 1'b1;
      end else if (issue) begin
        addr_r   <= addr_r + 1'b1;
        remain_r <= remain_r - 1'b1;
        first_r  <= 1'b0;
      end
      rd_vld <= issue;
      rd_sof <= issue & first_r;
      rd_eof <= issue & last;
    end
  end

  // Output FIFO
  assign pix_valid  = (fifo_count != 2'd0);
  assign pop        = pix_valid & pix_ready;
  assign pix_data   = fifo_data[rd_ptr];
  assign pix_sof    = pix_valid & fifo_sof[rd_ptr];
  assign pix_eof    = pix_valid & fifo_eof[rd_ptr];
  assign frame_done = pop & fifo_eof[rd_ptr] & ~scan_abort & ~reset;
  assign scan_busy  = (state != SCAN_IDLE);

  always_ff @(posedge clk) begin
    if (rd_vld) begin
      fifo_data[wr_ptr] <= b_q;
      fifo_sof[wr_ptr]  <= rd_sof;
      fifo_eof[wr_ptr]  <= rd_eof;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || scan_abort) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (rd_vld) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)    rd_ptr <= ptr_inc(rd_ptr);
      fifo_count <= fifo_count + 2'(rd_vld) - 2'(pop);
    end
  end

endmodule
